// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the SPI master arbiter.
package spi_arb_pkg;
  localparam int NBITS_W = 5;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  // Requested bit count of 0 or anything beyond the word width means a full word.
  function automatic logic [NBITS_W-1:0] eff_nbits(input logic [NBITS_W-1:0] n,
                                                   input logic [NBITS_W-1:0] wmax);
    return (n == '0 || n > wmax) ? wmax : n;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational search from the pointer, pointer advances past each grant.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);
  logic [IW-1:0] r_ptr;
  int            w_j;

  // Walk downward so the requester nearest the pointer is assigned last and wins.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = NREQ-1; k >= 0; k--) begin
      w_j = (int'(r_ptr) + k) % NREQ;
      if (i_req[w_j]) begin
        o_gnt      = '0;
        o_gnt[w_j] = 1'b1;
        o_idx      = IW'(w_j);
        o_any      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= '0;
    else if (i_en && o_any)
      r_ptr <= (o_idx == IW'(NREQ-1)) ? '0 : o_idx + 1'b1;
  end
endmodule

// File: rtl/spi_master_arbiter.sv
// Shared SPI mode-1 master: round-robin grant, CS framing, MSB-first shift of up to WIDTH bits.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int NREQ     = 3,
  parameter int WIDTH    = 24,
  parameter int CLKDIV   = 4,
  parameter int CS_SETUP = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ*NBITS_W-1:0] req_nbits,
  output logic [NREQ-1:0]         gnt,
  output logic                    done,
  output logic [WIDTH-1:0]        rdata,
  output logic                    busy,
  output logic                    spi_sclk,
  output logic                    spi_mosi,
  input  logic                    spi_miso,
  output logic [NREQ-1:0]         cs_n
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [15:0] DIV_LAST = 16'(CLKDIV - 1);
  localparam logic [15:0] CS_LAST  = 16'(CS_SETUP - 1);

  state_t               r_state, w_state_nxt;
  logic [15:0]          r_cnt;
  logic [NBITS_W-1:0]   r_bits;
  logic [WIDTH-1:0]     r_tx, r_rx, r_rdata;
  logic [NREQ-1:0]      r_gnt, r_cs_n;
  logic                 r_done, r_sclk, r_mosi;

  logic [NREQ-1:0]      w_gnt;
  logic [IW-1:0]        w_idx;
  logic                 w_any, w_grant, w_cnt_last;
  logic [WIDTH-1:0]     w_data;
  logic [NBITS_W-1:0]   w_nbits, w_shamt;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .i_req (req),
    .i_en  (w_grant),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_data     = req_data[int'(w_idx)*WIDTH +: WIDTH];
  assign w_nbits    = eff_nbits(req_nbits[int'(w_idx)*NBITS_W +: NBITS_W], NBITS_W'(WIDTH));
  assign w_shamt    = NBITS_W'(WIDTH) - w_nbits;
  assign w_cnt_last = (r_state == SHIFT) ? (r_cnt == DIV_LAST) : (r_cnt == CS_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    case (r_state)
      IDLE:  if (w_any) begin
               w_grant     = 1'b1;
               w_state_nxt = SETUP;
             end
      SETUP: if (w_cnt_last) w_state_nxt = SHIFT;
      SHIFT: if (w_cnt_last && !r_sclk && r_bits == '0) w_state_nxt = HOLD;
      HOLD:  if (w_cnt_last) w_state_nxt = GAP;
      GAP:   if (w_cnt_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // TX word is left-aligned at latch so every transfer shifts out of the top bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_bits  <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
      r_rdata <= '0;
      r_gnt   <= '0;
      r_cs_n  <= '1;
      r_done  <= 1'b0;
      r_sclk  <= 1'b0;
      r_mosi  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_cnt  <= (r_state == IDLE || w_cnt_last) ? '0 : r_cnt + 1'b1;
      case (r_state)
        IDLE: if (w_grant) begin
          r_gnt  <= w_gnt;
          r_cs_n <= ~w_gnt;
          r_tx   <= w_data << w_shamt;
          r_bits <= w_nbits;
          r_rx   <= '0;
          r_mosi <= 1'b0;
        end
        SETUP: if (w_cnt_last) begin
          r_sclk <= 1'b1;
          r_mosi <= r_tx[WIDTH-1];
          r_tx   <= r_tx << 1;
        end
        SHIFT: if (w_cnt_last) begin
          if (r_sclk) begin
            r_sclk <= 1'b0;
            r_rx   <= {r_rx[WIDTH-2:0], spi_miso};
            r_bits <= r_bits - 1'b1;
          end else if (r_bits != '0) begin
            r_sclk <= 1'b1;
            r_mosi <= r_tx[WIDTH-1];
            r_tx   <= r_tx << 1;
          end
        end
        HOLD: if (w_cnt_last) begin
          r_cs_n  <= '1;
          r_gnt   <= '0;
          r_done  <= 1'b1;
          r_rdata <= r_rx;
        end
        default: ;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign cs_n     = r_cs_n;
  assign done     = r_done;
  assign rdata    = r_rdata;
  assign busy     = (r_state != IDLE);
  assign spi_sclk = r_sclk;
  assign spi_mosi = r_mosi;
endmodule

// File: doc/spi_master_arbiter.md
Name: spi_master_arbiter

Overview:
- Internal SPI master that shares the single peripheral SPI bus (SCLK/MOSI/MISO) between NREQ on-chip requesters (ADC03 poller, DAC updater, flash loader).
- Grants the bus round-robin, drives the target's active-low chip select, and shifts a right-aligned word of up to WIDTH bits out and in.
- Sits between fabric requesters and the peripheral pins, replacing MCU pass-through for fabric-initiated transfers.

Parameters:
- NREQ, 3: number of requesters; requester i owns cs_n[i].
- WIDTH, 24: maximum bits per transfer.
- CLKDIV, 4: SCLK half-period in clk cycles, minimum 1.
- CS_SETUP, 2: clk cycles for CS-to-first-edge, last-edge-to-CS-release, and minimum CS-high gap, minimum 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester transfer request, level, held until done
- req_data  in  NREQ*WIDTH  per-requester TX word, right-aligned, slice i = bits [i*WIDTH +: WIDTH]
- req_nbits  in  NREQ*5  per-requester bit count; 0 means WIDTH
- gnt  out  NREQ  one-hot grant, high for the whole transaction
- done  out  1  one-cycle pulse at end of transaction
- rdata  out  WIDTH  received word, right-aligned, upper bits zero; valid when done is high, held until the next done
- busy  out  1  high when not IDLE
- spi_sclk  out  1  SPI clock, idles low
- spi_mosi  out  1  SPI data out
- spi_miso  in  1  SPI data in
- cs_n  out  NREQ  active-low chip selects, one-hot-low or all high

Behaviour:
- SPI mode 1 (CPOL=0, CPHA=1), MSB first. MOSI changes on the SCLK rising edge. Slave and master both sample on the falling edge.
- Reset values: gnt=0, done=0, rdata=0, busy=0, spi_sclk=0, spi_mosi=0, cs_n all 1, state IDLE, rr pointer=0.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
- IDLE:
  - Arbitrate when any req bit is high. Priority starts at (last granted + 1) mod NREQ; after reset it starts at 0.
  - On the next cycle: gnt one-hot, cs_n[i]=0, busy=1. Latch req_data and req_nbits (0 is replaced by WIDTH) into internal registers.
  - Requester inputs are ignored after the latch.
- SETUP: CS_SETUP cycles, SCLK low, MOSI=0.
- SHIFT, per bit:
  - SCLK high for CLKDIV cycles. MOSI is set to the next TX bit on the rising edge.
  - SCLK low for CLKDIV cycles. spi_miso is sampled into the RX shift register on the falling-edge cycle.
  - nbits periods in total, then SHIFT ends with SCLK low.
- HOLD: CS_SETUP cycles, SCLK low, MOSI held. At the end, cs_n goes all high, gnt goes 0, done pulses for 1 cycle, and rdata is loaded.
- GAP: CS_SETUP cycles, all CS high, busy=1. Then IDLE; arbitration may grant on the following cycle.
- CS low duration is exactly 2*CS_SETUP + 2*CLKDIV*nbits cycles.
- Fairness: a requester still holding req after its done is not re-granted while any other req is high.
- req deasserted before grant: no transfer. req deasserted during a transfer: ignored, and the transfer completes.
- req_nbits > WIDTH: clamp to WIDTH.
- rst mid-transfer: next cycle all outputs at reset values, no done pulse, rr pointer reset.
- Never more than one cs_n low. cs_n and gnt change only on the IDLE->SETUP and HOLD->GAP transitions.

Decomposition:
- Package spi_arb_pkg holds:
  - state enum (IDLE, SETUP, SHIFT, HOLD, GAP)
  - NBITS_W=5
  - a helper function for effective nbits (0->WIDTH, clamp).
- Sub-module rr_arbiter (NREQ param): inputs req, pointer, enable; output one-hot grant and index. It is purely combinational plus the pointer register.
- The shift/divider datapath stays in the top module.

Test Plan:
- CLKDIV=2, CS_SETUP=2. req[1]=1, req_data slice1=0xA5, nbits=8, MISO loopback from MOSI -> cs_n=3'b101 low for 36 cycles; 8 SCLK pulses; MOSI sampled on falling edges = 1,0,1,0,0,1,0,1; done once; rdata=0x0000A5.
- req=3'b111 held continuously through 4 transactions, nbits=4 -> grant order 0,1,2,0; each grant preceded by at least CS_SETUP cycles with cs_n=3'b111.
- req_nbits=0, req_data=0x800001, MISO tied 1 -> 24 SCLK pulses; first MOSI bit 1, last 1, the 22 between 0; rdata=0xFFFFFF.
- Assert rst at the 5th SCLK rising edge of a 16-bit transfer -> next cycle cs_n=all 1, sclk=0, gnt=0, busy=0; no done; a subsequent req[2] is granted normally.
- req[0] pulsed for 1 cycle while req[2] is mid-transfer -> no grant to 0 and no spurious CS. req[0] held -> granted only after the GAP of transfer 2.
